// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and elaboration-time helpers for the UART timing blocks.
//   ACC_W_DEF    : default phase accumulator width
//   calc_inc_def : rounded phase increment for a given clock / baud / ratio
//   calc_osw     : width of an oversample-ratio field (holds 0..OS_MAX)
//   clamp_os     : maps a requested ratio onto 1..OS_MAX (0 selects OS_MAX)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned ACC_W_DEF = 24;

    // round(baud * os_max * 2^acc_w / fclk_hz), evaluated in 64-bit arithmetic
    function automatic longint unsigned calc_inc_def(
        input longint unsigned fclk_hz,
        input longint unsigned baud,
        input longint unsigned os_max,
        input int unsigned     acc_w
    );
        longint unsigned num;
        num = baud * os_max * (64'd1 << acc_w);
        return (num + (fclk_hz / 2)) / fclk_hz;
    endfunction

    function automatic int unsigned calc_osw(input int unsigned os_max);
        return $clog2(os_max) + 1;
    endfunction

    function automatic int unsigned clamp_os(input int unsigned os, input int unsigned os_max);
        return ((os == 0) || (os > os_max)) ? os_max : os;
    endfunction

endpackage

// File: rtl/baud_gen_frac_os_divider.sv
// -----------------------------------------------------------------------------
// os_divider
// Divides the accumulator carry stream by the oversample ratio and produces
// the registered bit and mid-bit strobes.
//   CLK      in   system clock
//   rst      in   synchronous active-high reset
//   clr      in   restart bit phase (config load or resync); wins over counting
//   en       in   run enable; 0 holds the count and any pending strobe
//   carry    in   accumulator carry this cycle (already qualified by en/clr)
//   os_n     in   oversample ratio, 1..OS_MAX
//   bit_raw  out  registered bit strobe, before output gating
//   mid_raw  out  registered mid-bit strobe, before output gating
// -----------------------------------------------------------------------------
module os_divider #(
    parameter int unsigned OSW = 5
) (
    input  logic           CLK,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic           carry,
    input  logic [OSW-1:0] os_n,
    output logic           bit_raw,
    output logic           mid_raw
);

    logic [OSW-1:0] os_mod_q, os_mod_d;
    logic           bit_q, bit_d;
    logic           mid_q, mid_d;
    logic           last;
    logic           mid_hit;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // through the block leaves one unassigned and infers a latch.
        os_mod_d = os_mod_q;
        bit_d    = bit_q;
        mid_d    = mid_q;

        last = (os_mod_q == (os_n - OSW'(1)));
        // With a ratio of 1 there is no distinct mid point, so the mid strobe
        // rides on every bit strobe.
        mid_hit = (os_n == OSW'(1)) ? last : (os_mod_q == ((os_n >> 1) - OSW'(1)));

        if (clr) begin
            os_mod_d = '0;
            bit_d    = 1'b0;
            mid_d    = 1'b0;
        end else if (en) begin
            bit_d = carry && last;
            mid_d = carry && mid_hit;
            if (carry) begin
                os_mod_d = last ? '0 : (os_mod_q + OSW'(1));
            end
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            os_mod_q <= '0;
            bit_q    <= 1'b0;
            mid_q    <= 1'b0;
        end else begin
            os_mod_q <= os_mod_d;
            bit_q    <= bit_d;
            mid_q    <= mid_d;
        end
    end

    assign bit_raw = bit_q;
    assign mid_raw = mid_q;

endmodule

// File: rtl/baud_gen_frac.sv
// -----------------------------------------------------------------------------
// baud_gen_frac
// Fractional-N baud / oversample tick generator. A phase accumulator adds a
// programmable increment every enabled cycle; each carry is one oversample
// tick, and every os_n-th tick is a bit tick, with a mid-bit strobe halfway.
//   CLK        in   system clock
//   rst        in   synchronous active-high reset
//   en         in   run enable; 0 freezes phase, count and pending strobes
//   resync     in   single-cycle pulse, realigns bit phase to zero
//   cfg_valid  in   config request
//   cfg_ready  out  config accept (drops for one cycle after each accept)
//   cfg_inc    in   new phase increment
//   cfg_os     in   new oversample ratio (0 or > OS_MAX selects OS_MAX)
//   os_tick    out  oversample strobe
//   bit_tick   out  1x baud strobe
//   mid_tick   out  mid-bit sample strobe
//   tick_cnt   out  bit_tick count, only with BAUD_TICK_CNT_EN defined
// Optional feature macro: BAUD_TICK_CNT_EN
// -----------------------------------------------------------------------------
module baud_gen_frac
    import uart_pkg::*;
#(
    parameter longint unsigned FCLK_HZ = 100_000_000,
    parameter longint unsigned BAUD    = 3_125_000,
    parameter int unsigned     OS_MAX  = 16,
    parameter int unsigned     ACC_W   = ACC_W_DEF
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     resync,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [ACC_W-1:0]         cfg_inc,
    input  logic [$clog2(OS_MAX):0]  cfg_os,
    output logic                     os_tick,
    output logic                     bit_tick,
    output logic                     mid_tick
`ifdef BAUD_TICK_CNT_EN
    ,
    output logic [15:0]              tick_cnt
`endif
);

    localparam int unsigned     OSW     = calc_osw(OS_MAX);
    localparam longint unsigned INC_DEF = calc_inc_def(FCLK_HZ, BAUD, longint'(OS_MAX), ACC_W);
    localparam logic [ACC_W-1:0] INC_INIT = INC_DEF[ACC_W-1:0];

    if ((INC_DEF == 0) || (INC_DEF >= (64'd1 << ACC_W))) begin : g_bad_inc
        $error("baud_gen_frac: default increment out of range for ACC_W");
    end

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [OSW-1:0]   os_n_q, os_n_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             os_tick_q, os_tick_d;
    logic [ACC_W:0]   sum;
    logic             cfg_load;
    logic             clr;
    logic             carry;
    logic             bit_raw, mid_raw;

    always_comb begin
        acc_d       = acc_q;
        inc_d       = inc_q;
        os_n_d      = os_n_q;
        os_tick_d   = os_tick_q;
        cfg_ready_d = 1'b1;

        sum      = {1'b0, acc_q} + {1'b0, inc_q};
        cfg_load = cfg_valid && cfg_ready_q;
        clr      = cfg_load || resync;
        carry    = en && !clr && sum[ACC_W];

        // Config load outranks resync; both restart the bit phase and drop
        // any strobe that would otherwise have followed this cycle.
        if (cfg_load) begin
            inc_d       = cfg_inc;
            os_n_d      = OSW'(clamp_os(32'(cfg_os), OS_MAX));
            acc_d       = '0;
            os_tick_d   = 1'b0;
            cfg_ready_d = 1'b0;
        end else if (resync) begin
            acc_d     = '0;
            os_tick_d = 1'b0;
        end else if (en) begin
            acc_d     = sum[ACC_W-1:0];
            os_tick_d = sum[ACC_W];
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            acc_q       <= '0;
            inc_q       <= INC_INIT;
            os_n_q      <= OSW'(OS_MAX);
            cfg_ready_q <= 1'b1;
            os_tick_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            inc_q       <= inc_d;
            os_n_q      <= os_n_d;
            cfg_ready_q <= cfg_ready_d;
            os_tick_q   <= os_tick_d;
        end
    end

    os_divider #(
        .OSW (OSW)
    ) u_os_divider (
        .CLK     (CLK),
        .rst     (rst),
        .clr     (clr),
        .en      (en),
        .carry   (carry),
        .os_n    (os_n_q),
        .bit_raw (bit_raw),
        .mid_raw (mid_raw)
    );

    // A strobe registered just before en drops is held in its flop and shown
    // on the first enabled cycle, so pausing never loses or repeats a tick.
    // Gating with rst keeps the outputs quiet during the reset cycle itself.
    assign os_tick   = os_tick_q && en && !rst;
    assign bit_tick  = bit_raw   && en && !rst;
    assign mid_tick  = mid_raw   && en && !rst;
    assign cfg_ready = cfg_ready_q;

`ifdef BAUD_TICK_CNT_EN
    logic [15:0] tick_cnt_q, tick_cnt_d;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (cfg_load) begin
            tick_cnt_d = '0;
        end else if (bit_tick) begin
            tick_cnt_d = tick_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_baud_gen_frac.sv
// -----------------------------------------------------------------------------
// tb_baud_gen_frac
// Self-checking bench for baud_gen_frac. The reference model counts enabled
// cycles since the last phase restart and derives every strobe from the total
// phase n*inc with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_baud_gen_frac;

    localparam logic [23:0] INC_DEF = 24'h800000;

    logic        CLK = 1'b0;
    logic        rst;
    logic        en;
    logic        resync;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [23:0] cfg_inc;
    logic [4:0]  cfg_os;
    logic        os_tick;
    logic        bit_tick;
    logic        mid_tick;
`ifdef BAUD_TICK_CNT_EN
    logic [15:0] tick_cnt;
`endif

    always #5 CLK = ~CLK;

    baud_gen_frac dut (
        .CLK       (CLK),
        .rst       (rst),
        .en        (en),
        .resync    (resync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_inc   (cfg_inc),
        .cfg_os    (cfg_os),
        .os_tick   (os_tick),
        .bit_tick  (bit_tick),
        .mid_tick  (mid_tick)
`ifdef BAUD_TICK_CNT_EN
        ,
        .tick_cnt  (tick_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc_no = 0;

    // Reference model state
    longint unsigned m_inc;
    longint unsigned m_osn;
    longint unsigned m_n;      // enabled cycles since the last restart
    logic            m_ready;
    logic [15:0]     m_cnt;

    // Observed os_tick statistics for the long fractional run
    int os_seen;
    int last_os;
    int min_sp;
    int max_sp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
        end
    endtask

    // Strobes seen in enabled cycle n after a restart: a tick shows one cycle
    // after the phase crosses a multiple of 2^24, i.e. when the number of
    // whole turns completed in n-1 steps exceeds that in n-2 steps.
    task automatic exp_ticks(input longint unsigned n, input longint unsigned inc,
                             input longint unsigned osn,
                             output logic o, output logic b, output logic m);
        longint unsigned c_now, c_prev;
        o = 1'b0;
        b = 1'b0;
        m = 1'b0;
        if (n >= 2) begin
            c_now  = ((n - 1) * inc) >> 24;
            c_prev = ((n - 2) * inc) >> 24;
            if (c_now > c_prev) begin
                o = 1'b1;
                b = ((c_now % osn) == 0);
                m = (osn == 1) ? b : ((c_now % osn) == (osn / 2));
            end
        end
    endtask

    task automatic model_reset();
        m_inc   = longint'(INC_DEF);
        m_osn   = 16;
        m_n     = 0;
        m_ready = 1'b1;
        m_cnt   = '0;
    endtask

    task automatic step(input logic r, input logic e, input logic rs, input logic v,
                        input logic [23:0] ci, input logic [4:0] co);
        logic eo, eb, em;
        rst       = r;
        en        = e;
        resync    = rs;
        cfg_valid = v;
        cfg_inc   = ci;
        cfg_os    = co;
        @(negedge CLK);
        cyc_no++;
        eo = 1'b0;
        eb = 1'b0;
        em = 1'b0;
        if (!r && e) exp_ticks(m_n + 1, m_inc, m_osn, eo, eb, em);
        check("os_tick",   32'(os_tick),   32'(eo));
        check("bit_tick",  32'(bit_tick),  32'(eb));
        check("mid_tick",  32'(mid_tick),  32'(em));
        check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
`ifdef BAUD_TICK_CNT_EN
        check("tick_cnt",  32'(tick_cnt),  32'(m_cnt));
`endif
        if (os_tick) begin
            os_seen++;
            if (last_os >= 0) begin
                if (cyc_no - last_os < min_sp) min_sp = cyc_no - last_os;
                if (cyc_no - last_os > max_sp) max_sp = cyc_no - last_os;
            end
            last_os = cyc_no;
        end
        if (r) begin
            model_reset();
        end else if (v && m_ready) begin
            m_inc   = longint'(ci);
            m_osn   = ((co == 0) || (co > 16)) ? 16 : longint'(co);
            m_n     = 0;
            m_ready = 1'b0;
            m_cnt   = '0;
        end else begin
            m_ready = 1'b1;
            if (eb) m_cnt = m_cnt + 16'd1;
            if (rs) m_n = 0;
            else if (e) m_n = m_n + 1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int cycles, input logic e);
        for (int i = 0; i < cycles; i++) step(1'b0, e, 1'b0, 1'b0, 24'h0, 5'd0);
    endtask

    task automatic clear_stats();
        os_seen = 0;
        last_os = -1;
        min_sp  = 1_000_000;
        max_sp  = 0;
    endtask

    initial begin
        logic [23:0] r_inc;
        int          pick;
        clear_stats();
        rst = 1'b1; en = 1'b0; resync = 1'b0; cfg_valid = 1'b0;
        cfg_inc = '0; cfg_os = '0;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();

        // Reset state, then more reset cycles with en high
        step(1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 5'd0);
        run(2, 1'b0);

        // Defaults: os every 2, bit every 32, mid halfway
        run(100, 1'b1);

        // Pause mid-bit for 10 cycles
        run(10, 1'b0);
        run(80, 1'b1);

        // Fractional increment over 3000 enabled cycles
        step(1'b0, 1'b1, 1'b0, 1'b1, 24'h555555, 5'd16);
        clear_stats();
        run(3000, 1'b1);
        check("frac_os_count", 32'(os_seen), 32'd999);
        check("frac_spacing_3_or_4", 32'(min_sp >= 3 && max_sp <= 4), 32'd1);

        // Ratio 1: all three strobes coincide
        step(1'b0, 1'b1, 1'b0, 1'b1, 24'h800000, 5'd1);
        run(20, 1'b1);

        // Resync in the cycle that would carry
        step(1'b0, 1'b1, 1'b0, 1'b1, 24'h800000, 5'd16);
        run(1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 5'd0);
        run(70, 1'b1);

        // Resync and config in the same cycle: config wins
        step(1'b0, 1'b1, 1'b1, 1'b1, 24'h400000, 5'd8);
        run(80, 1'b1);

        // Clamp boundaries: 0 and >OS_MAX both mean 16
        step(1'b0, 1'b1, 1'b0, 1'b1, 24'hC00000, 5'd0);
        run(40, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 24'hC00000, 5'd31);
        run(40, 1'b1);

        // Zero increment never ticks
        step(1'b0, 1'b1, 1'b0, 1'b1, 24'h000000, 5'd4);
        run(30, 1'b1);

        // Reset while ticking after a config load restores defaults
        step(1'b0, 1'b1, 1'b0, 1'b1, 24'hAAAAAA, 5'd3);
        run(30, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 5'd0);
        run(70, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            pick = int'($urandom_range(0, 5));
            case (pick)
                0:       r_inc = 24'h000000;
                1:       r_inc = 24'h800000;
                2:       r_inc = 24'h555555;
                3:       r_inc = 24'hFFFFFF;
                default: r_inc = 24'($urandom);
            endcase
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 29) == 0,
                 r_inc,
                 5'($urandom_range(0, 31)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
